// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and EX-stage data accesses.
// Address phases are arbitrated here; an order FIFO steers the in-order responses back to their owner.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_address,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        protocol_error
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_INST,
        LOCK_DATA
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             sel_data;
    logic             handshake;
    logic             push;
    logic             pop;
    logic             full;
    logic             head_src;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve;
    logic             order_q [MAX_OUTSTANDING];

    assign full = (count == FULL_COUNT);

    always_comb begin
        // NOTE: every output of this block is given a default first so no latch is inferred.
        next_state = state;
        mem_req    = 1'b0;
        sel_data   = 1'b0;
        case (state)
            IDLE: begin
                if (!full) begin
                    if (data_req && !(inst_req && starve == STARVE_MAX)) begin
                        mem_req  = 1'b1;
                        sel_data = 1'b1;
                    end else if (inst_req) begin
                        mem_req  = 1'b1;
                        sel_data = 1'b0;
                    end
                end
                if (mem_req && !mem_addr_ok) begin
                    next_state = sel_data ? LOCK_DATA : LOCK_INST;
                end
            end
            // A locked source keeps the port even if the other side asks meanwhile.
            LOCK_INST: begin
                mem_req  = 1'b1;
                sel_data = 1'b0;
                if (mem_addr_ok) next_state = IDLE;
            end
            LOCK_DATA: begin
                mem_req  = 1'b1;
                sel_data = 1'b1;
                if (mem_addr_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem_wr      = sel_data ? data_wr      : 1'b0;
    assign mem_size    = sel_data ? data_size    : 2'd2;
    assign mem_address = sel_data ? data_address : inst_address;
    assign mem_wdata   = sel_data ? data_wdata   : 32'd0;

    assign handshake    = mem_req & mem_addr_ok;
    assign inst_addr_ok = handshake & ~sel_data;
    assign data_addr_ok = handshake & sel_data;

    // Source ID: 0 = inst, 1 = data.
    assign push     = handshake;
    assign pop      = mem_data_ok & (count != '0);
    assign head_src = order_q[rd_ptr];

    assign inst_data_ok = pop & ~head_src;
    assign data_data_ok = pop & head_src;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            starve         <= '0;
            protocol_error <= 1'b0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!inst_req || inst_addr_ok) begin
                starve <= '0;
            end else if (data_addr_ok && starve < STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
            if (mem_data_ok && count == '0) protocol_error <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) order_q[wr_ptr] <= sel_data;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: per-cycle vector table plus hand-written lock and error/reset sequences.
module tb_sram_like_arbiter;

    localparam logic [31:0] IADDR = 32'hBFC0_0000;
    localparam logic [31:0] DADDR = 32'h8000_0010;
    localparam logic [31:0] DWDAT = 32'h1234_5678;

    logic        clock;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_address;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        protocol_error;

    int n_total;
    int n_pass;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .inst_req       (inst_req),
        .inst_address   (inst_address),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_address   (data_address),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .mem_size       (mem_size),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_addr_ok    (mem_addr_ok),
        .mem_data_ok    (mem_data_ok),
        .mem_rdata      (mem_rdata),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One record per clock cycle: inputs, then expected outputs (e_sel = data owns the port).
    typedef struct packed {
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic        e_sel;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
        logic        e_perr;
    } vec_t;

    function automatic vec_t mk(input logic ireq, dreq, dwr, maok, mdok, input logic [31:0] mrdata,
                                input logic e_mreq, e_sel, e_iaok, e_daok, e_idok, e_ddok, e_perr);
        vec_t v;
        v.ireq = ireq;     v.dreq = dreq;     v.dwr = dwr;
        v.maok = maok;     v.mdok = mdok;     v.mrdata = mrdata;
        v.e_mreq = e_mreq; v.e_sel = e_sel;
        v.e_iaok = e_iaok; v.e_daok = e_daok;
        v.e_idok = e_idok; v.e_ddok = e_ddok;
        v.e_perr = e_perr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ireq, dreq, dwr, maok, mdok, input logic [31:0] rd);
        reset       = rst;
        inst_req    = ireq;
        data_req    = dreq;
        data_wr     = dwr;
        mem_addr_ok = maok;
        mem_data_ok = mdok;
        mem_rdata   = rd;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply(input int idx, input vec_t v);
        drive(1'b0, v.ireq, v.dreq, v.dwr, v.maok, v.mdok, v.mrdata);
        #1;
        check($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.e_mreq));
        if (v.e_mreq) begin
            check($sformatf("v%0d mem_address", idx), mem_address, v.e_sel ? DADDR : IADDR);
            check($sformatf("v%0d mem_wr", idx), 32'(mem_wr), v.e_sel ? 32'(v.dwr) : 32'd0);
            check($sformatf("v%0d mem_size", idx), 32'(mem_size), v.e_sel ? 32'd0 : 32'd2);
            check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_sel ? DWDAT : 32'd0);
        end
        check($sformatf("v%0d inst_addr_ok", idx), 32'(inst_addr_ok), 32'(v.e_iaok));
        check($sformatf("v%0d data_addr_ok", idx), 32'(data_addr_ok), 32'(v.e_daok));
        check($sformatf("v%0d inst_data_ok", idx), 32'(inst_data_ok), 32'(v.e_idok));
        check($sformatf("v%0d data_data_ok", idx), 32'(data_data_ok), 32'(v.e_ddok));
        check($sformatf("v%0d protocol_error", idx), 32'(protocol_error), 32'(v.e_perr));
        if (v.e_idok) check($sformatf("v%0d inst_rdata", idx), inst_rdata, v.mrdata);
        if (v.e_ddok) check($sformatf("v%0d data_rdata", idx), data_rdata, v.mrdata);
        tick();
    endtask

    vec_t vecs [23];

    initial begin
        n_total      = 0;
        n_pass       = 0;
        inst_address = IADDR;
        data_address = DADDR;
        data_wdata   = DWDAT;
        data_size    = 2'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);

        //              ireq dreq dwr maok mdok rdata           mreq sel iaok daok idok ddok perr
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single fetch, response three cycles after the handshake.
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h24010001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Collision: data first, then inst; responses routed in order.
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5555FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Starvation: three data wins, then inst forced; FIFO becomes full.
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Full: no request; a pop does not unblock the same cycle, only the next.
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Drain: data, data, inst, data.
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Store handshake together with a pop of the earlier fetch.
        vecs[20] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h66666666, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 23; i++) begin
            apply(i, vecs[i]);
        end

        // Lock: data holds the port through four cycles of mem_addr_ok low while inst toggles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            #1;
            check($sformatf("lock%0d mem_req", i), 32'(mem_req), 32'd1);
            check($sformatf("lock%0d mem_address", i), mem_address, DADDR);
            check($sformatf("lock%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'd0);
            check($sformatf("lock%0d data_addr_ok", i), 32'(data_addr_ok), 32'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        check("lock_release mem_address", mem_address, DADDR);
        check("lock_release data_addr_ok", 32'(data_addr_ok), 32'd1);
        check("lock_release inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        check("after_lock inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("after_lock mem_address", mem_address, IADDR);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
        #1;
        check("lock_drain0 data_data_ok", 32'(data_data_ok), 32'd1);
        check("lock_drain0 data_rdata", data_rdata, 32'h0BAD_F00D);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001);
        #1;
        check("lock_drain1 inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("lock_drain1 inst_rdata", inst_rdata, 32'hC0DE_0001);
        tick();

        // Error: response with nothing outstanding.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("err inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("err data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("err protocol_error set", 32'(protocol_error), 32'd1);
        tick();
        // One outstanding fetch, then data locks the port, then reset mid-LOCKED.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        check("pre_rst inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("pre_rst data mem_req", 32'(mem_req), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("rst_cycle locked mem_req", 32'(mem_req), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("post_rst mem_req", 32'(mem_req), 32'd0);
        check("post_rst protocol_error", 32'(protocol_error), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF);
        #1;
        check("post_rst empty inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("post_rst empty data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("post_rst protocol_error set", 32'(protocol_error), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
